lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store unit that drives the MEM-stage `data_memory` port on behalf of the pipeline. It accepts one byte-addressed load or store per request, converts it to the memory's 64-bit-word indexing, performs read-modify-write for sub-doubleword stores, and returns sign- or zero-extended load data. It sits between the EX/MEM pipeline register and `data_memory`, and stalls the pipeline while an access is in flight.

## Interface
Parameters:
- `IDX_W`, default 10: word-index width used by `data_memory`. `add` carries `IDX_W` significant bits; the upper bits are zero.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: the pipeline presents a request.
- `req_ready`  out  1: the unit can accept a request. High only in IDLE.
- `req_we`  in  1: 1 for a store, 0 for a load.
- `req_size`  in  2: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
- `req_unsigned`  in  1: zero-extend load data (LBU/LHU/LWU).
- `req_addr`  in  64: byte address.
- `req_wdata`  in  64: store data, right-aligned.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_rdata`  out  64: extended load data. Zero for stores.
- `resp_err`  out  1: misaligned access. Valid with `resp_valid`.
- `stall`  out  1: `req_valid & ~req_ready`, or any non-IDLE state.
- `memread`, `memwrite`  out  1 each: drive `data_memory`.
- `add`  out  64: word index, `{zeros, addr[IDX_W+2:3]}`.
- `write_data`  out  64: merged doubleword.
- `read_data`  in  64: combinational read data from `data_memory`.

## Operation
- States are IDLE, READ, WRITE and RESP. Reset puts the unit in IDLE. All outputs are 0 at reset except `req_ready`, which is 1.
- Accept condition: `req_valid & req_ready`. On accept, latch we/size/unsigned/addr/wdata. `offset = addr[2:0]`.
- Misaligned: `offset` is not a multiple of `1<<size`. Go IDLE→RESP with `resp_err=1` and no memory access.
- Load: IDLE→READ→RESP. In READ, `memread=1`. Capture `read_data >> (8*offset)`, truncated to the size and extended per `req_unsigned`. For doubleword loads, `req_unsigned` is ignored.
- Store, doubleword: IDLE→WRITE→RESP. `write_data = wdata`.
- Store, smaller sizes: IDLE→READ→WRITE→RESP.
  - READ captures the old word.
  - WRITE drives the old word with bytes `[offset +: 1<<size]` replaced by the low bytes of `wdata`.
- In READ and WRITE, `add` and `write_data` come from latched registers and are stable for the whole cycle.
- `memwrite` is high for exactly one cycle per store.
- `memread` and `memwrite` are never high together.
- In RESP, `resp_valid=1`, then the unit returns to IDLE. `resp_valid` has no backpressure.
- `req_valid` while not ready is ignored. The pipeline holds it, because `stall` is high.

## Timing
- Accept at edge 0.
- Doubleword store: `memwrite` in cycle 1, `resp_valid` in cycle 2.
- Load: `memread` in cycle 1, `resp_valid` in cycle 2.
- Sub-doubleword store: `memread` in cycle 1, `memwrite` in cycle 2, `resp_valid` in cycle 3.
- Misaligned: `resp_valid` in cycle 1.
- Back-to-back: the next request is accepted in the cycle after RESP (IDLE). Peak throughput is 1 access per 3 cycles for loads.
- Reset mid-operation:
  - State returns to IDLE asynchronously.
  - `memwrite` and `memread` drop immediately.
  - `resp_valid` is not generated.
  - A reset during WRITE must not leave a partial merge. The memory keeps either the old or the new word, never a mix.
- Address wrap: index bits above `IDX_W+2` are discarded. No error is flagged.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: misalignment detection and `resp_err` as described above.
- Not defined:
  - `resp_err` is tied to 0.
  - `offset` is forced to natural alignment: low `size` bits cleared.
  - The access proceeds normally.

## Structure
- The shared package `lsu_pkg` holds:
  - the size encodings (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`);
  - the state enum `lsu_state_t`;
  - a `byte_mask(size, offset)` function that returns an 8-bit byte-enable.
- One sub-module, `lsu_align`, is purely combinational and does two things:
  - load extract/extend;
  - store merge with the old word.
- The FSM and latches stay in `lsu_mem_port`.

## Test plan
- After reset (memory[i]=i): LD at 0x28 → `memread` asserted with `add=5`; `resp_rdata=5` two cycles after accept; `resp_err=0`.
- SD 0xFFFF_FFFF_FFFF_FF80 at 0x10, then LB at 0x10 → 0xFFFF_FFFF_FFFF_FF80. LBU at 0x10 → 0x80. LW at 0x14 → 0xFFFF_FFFF_FFFF_FFFF.
- SH 0xBEEF at 0x1A → READ then WRITE at `add=3`, `write_data=0x0000_0000_BEEF_0003`. `memwrite` is high for exactly 1 cycle and `resp_valid` arrives in cycle 3.
- LW at 0x06:
  - with `LSU_ALIGN_CHECK_EN`: `resp_err=1` in cycle 1, with no `memread` or `memwrite` pulse;
  - without it: reads word 0 at offset 4 and returns 0.
- Assert `reset` in the WRITE cycle of SB 0xAA at 0x08 → `memwrite` falls the same cycle, state is IDLE, no `resp_valid`, and `req_ready=1` after reset release.
- Hold `req_valid` for two loads back-to-back → the second is accepted in the cycle after the first `resp_valid`, and `stall` is high throughout each access.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings, FSM
// state type and byte-enable helpers used by the FSM and the align datapath.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_lsb_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    // Byte enables within the doubleword for an access of 'size' at 'offset'.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte lane logic: load extract/extend and store merge of the
// new bytes into the old doubleword.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] ld_word,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [2:0]  offset,
    output logic [63:0] ld_data,
    input  logic [63:0] st_old,
    input  logic [63:0] st_wdata,
    output logic [63:0] st_word
);

    logic [63:0] ld_shift;
    logic [63:0] st_shift;
    logic [7:0]  st_mask;

    // Shift the addressed bytes down, truncate to size and extend.
    always_comb begin
        ld_shift = ld_word >> {offset, 3'b000};
        case (size)
            SZ_B:    ld_data = ld_unsigned ? {56'd0, ld_shift[7:0]}
                                           : {{56{ld_shift[7]}}, ld_shift[7:0]};
            SZ_H:    ld_data = ld_unsigned ? {48'd0, ld_shift[15:0]}
                                           : {{48{ld_shift[15]}}, ld_shift[15:0]};
            SZ_W:    ld_data = ld_unsigned ? {32'd0, ld_shift[31:0]}
                                           : {{32{ld_shift[31]}}, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Replace the enabled byte lanes of the old word with the shifted store data.
    always_comb begin
        st_shift = st_wdata << {offset, 3'b000};
        st_mask  = byte_mask(size, offset);
        st_word  = st_old;
        for (int i = 0; i < 8; i++) begin
            if (st_mask[i]) begin
                st_word[8*i +: 8] = st_shift[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit driving the data_memory port from the MEM stage.
// Build option: define LSU_ALIGN_CHECK_EN to flag misaligned accesses via
// resp_err; otherwise the offset is forced to natural alignment.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready, waiting for req_valid
// ST_READ  | memread; load data or old word (sub-doubleword store) captured
// ST_WRITE | memwrite of the fully merged doubleword held in a register
// ST_RESP  | resp_valid pulse, then back to idle
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic        memread,
    output logic        memwrite,
    output logic [63:0] add,
    output logic [63:0] write_data,
    input  logic [63:0] read_data
);

    lsu_state_t       state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [2:0]       offset_q, offset_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [63:0]      wr_q, wr_d;
    logic [63:0]      rdata_q, rdata_d;

    logic             accept;
    logic [2:0]       req_lsb;
    logic [2:0]       req_offset;
    logic             req_misaligned;
    logic [63:0]      ld_data;
    logic [63:0]      st_word;
    logic             unused_addr_hi;

    // Index bits above the memory size are discarded (address wraps).
    assign unused_addr_hi = ^req_addr[63:IDX_W+3];

    assign accept  = req_valid & req_ready;
    assign req_lsb = size_lsb_mask(req_size);

`ifdef LSU_ALIGN_CHECK_EN
    logic err_q, err_d;
    assign req_offset     = req_addr[2:0];
    assign req_misaligned = |(req_addr[2:0] & req_lsb);
`else
    assign req_offset     = req_addr[2:0] & ~req_lsb;
    assign req_misaligned = 1'b0;
`endif

    lsu_align u_align (
        .ld_word     (read_data),
        .size        (size_q),
        .ld_unsigned (uns_q),
        .offset      (offset_q),
        .ld_data     (ld_data),
        .st_old      (read_data),
        .st_wdata    (wdata_q),
        .st_word     (st_word)
    );

    // State register; reset aborts any access immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_misaligned)                    state_d = ST_RESP;
                    else if (req_we && req_size == SZ_D)   state_d = ST_WRITE;
                    else                                   state_d = ST_READ;
                end
            end
            ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request latches and captured data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            size_q   <= SZ_B;
            uns_q    <= 1'b0;
            offset_q <= 3'd0;
            idx_q    <= '0;
            wdata_q  <= 64'd0;
            wr_q     <= 64'd0;
            rdata_q  <= 64'd0;
`ifdef LSU_ALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            offset_q <= offset_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
`ifdef LSU_ALIGN_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    // Latch the request on accept; in READ capture load data or the merged
    // store word so WRITE drives a complete doubleword from a register.
    always_comb begin
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        offset_d = offset_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
`ifdef LSU_ALIGN_CHECK_EN
        err_d    = err_q;
`endif
        if (state_q == ST_IDLE && accept) begin
            we_d     = req_we;
            size_d   = req_size;
            uns_d    = req_unsigned;
            offset_d = req_offset;
            idx_d    = req_addr[IDX_W+2:3];
            wdata_d  = req_wdata;
            wr_d     = req_wdata;
            rdata_d  = 64'd0;
`ifdef LSU_ALIGN_CHECK_EN
            err_d    = req_misaligned;
`endif
        end else if (state_q == ST_READ) begin
            if (we_q) begin
                wr_d = st_word;
            end else begin
                rdata_d = ld_data;
            end
        end
    end

    // Outputs decoded from state; memory strobes fall as soon as reset hits.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        memread    = (state_q == ST_READ);
        memwrite   = (state_q == ST_WRITE);
        resp_valid = (state_q == ST_RESP);
        add        = 64'd0;
        write_data = 64'd0;
        resp_rdata = 64'd0;
        resp_err   = 1'b0;
        if (state_q == ST_READ || state_q == ST_WRITE) begin
            add = {{(64-IDX_W){1'b0}}, idx_q};
        end
        if (state_q == ST_WRITE) begin
            write_data = wr_q;
        end
        if (state_q == ST_RESP) begin
            resp_rdata = rdata_q;
`ifdef LSU_ALIGN_CHECK_EN
            resp_err   = err_q;
`endif
        end
        stall = (req_valid & ~req_ready) | (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a word-indexed memory model whose
// unwritten words read back as their own index.
module tb_lsu_mem_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, stall, memread, memwrite;
    logic [63:0] resp_rdata, add, write_data, read_data;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem_port #(.IDX_W(10)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .stall(stall), .memread(memread), .memwrite(memwrite),
        .add(add), .write_data(write_data), .read_data(read_data)
    );

    always #5 clock = ~clock;

    logic [63:0] mem [0:1023];
    bit   [1023:0] mem_wr;
    logic [9:0]  mem_idx;
    assign mem_idx   = add[9:0];
    assign read_data = mem_wr[mem_idx] ? mem[mem_idx] : {54'd0, mem_idx};
    always @(posedge clock) begin
        if (memwrite) begin
            mem[mem_idx]    <= write_data;
            mem_wr[mem_idx] <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          rd_cnt, rd_cyc, wr_cnt, wr_cyc, resp_cyc, overlap, stall_lo;
    logic [63:0] rd_add, wr_add, wr_dat, r_data;
    logic        r_err, rdy_acc;

    // One request from idle; records per-cycle activity until resp_valid.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wd);
        rd_cnt = 0; rd_cyc = 0; wr_cnt = 0; wr_cyc = 0; resp_cyc = 0;
        overlap = 0; stall_lo = 0; rd_add = 0; wr_add = 0; wr_dat = 0;
        r_data = 0; r_err = 0;
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(negedge clock);
        rdy_acc = req_ready;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (!stall) stall_lo++;
            if (memread && memwrite) overlap++;
            if (memread) begin
                rd_cnt++;
                if (rd_cyc == 0) rd_cyc = c;
                rd_add = add;
            end
            if (memwrite) begin
                wr_cnt++;
                wr_cyc = c;
                wr_add = add;
                wr_dat = write_data;
            end
            if (resp_valid) begin
                resp_cyc = c;
                r_data   = resp_rdata;
                r_err    = resp_err;
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic load_chk(input string tag, input logic [1:0] size, input logic uns,
                            input logic [63:0] addr, input logic [63:0] exp);
        do_req(1'b0, size, uns, addr, 64'd0);
        check_eq({tag, "_data"}, r_data, exp);
        check_eq({tag, "_resp_cyc"}, 64'(resp_cyc), 64'd2);
        check_eq({tag, "_err"}, {63'd0, r_err}, 64'd0);
    endtask

    int          first_resp, acc2, second_resp, stall_bad, resp_in_rst;
    logic [63:0] d1, d2;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        check_eq("rst_ready",  {63'd0, req_ready},  64'd1);
        check_eq("rst_resp",   {63'd0, resp_valid}, 64'd0);
        check_eq("rst_memrd",  {63'd0, memread},    64'd0);
        check_eq("rst_memwr",  {63'd0, memwrite},   64'd0);
        check_eq("rst_stall",  {63'd0, stall},      64'd0);
        check_eq("rst_err",    {63'd0, resp_err},   64'd0);
        check_eq("rst_add",    add,                 64'd0);
        check_eq("rst_wdata",  write_data,          64'd0);
        check_eq("rst_rdata",  resp_rdata,          64'd0);
        @(posedge clock);
        #1;

        // LD at 0x28 reads word 5
        do_req(1'b0, 2'd3, 1'b0, 64'h28, 64'd0);
        check_eq("ld28_ready",    {63'd0, rdy_acc}, 64'd1);
        check_eq("ld28_rd_cyc",   64'(rd_cyc),   64'd1);
        check_eq("ld28_add",      rd_add,        64'd5);
        check_eq("ld28_resp_cyc", 64'(resp_cyc), 64'd2);
        check_eq("ld28_data",     r_data,        64'd5);
        check_eq("ld28_err",      {63'd0, r_err}, 64'd0);
        check_eq("ld28_wr_cnt",   64'(wr_cnt),   64'd0);
        check_eq("ld28_stall",    64'(stall_lo), 64'd0);

        // SD straight to WRITE
        do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'hFFFF_FFFF_FFFF_FF80);
        check_eq("sd_wr_cyc",   64'(wr_cyc),   64'd1);
        check_eq("sd_wr_cnt",   64'(wr_cnt),   64'd1);
        check_eq("sd_rd_cnt",   64'(rd_cnt),   64'd0);
        check_eq("sd_add",      wr_add,        64'd2);
        check_eq("sd_wdata",    wr_dat,        64'hFFFF_FFFF_FFFF_FF80);
        check_eq("sd_resp_cyc", 64'(resp_cyc), 64'd2);
        check_eq("sd_rdata",    r_data,        64'd0);

        load_chk("lb10",  2'd0, 1'b0, 64'h10, 64'hFFFF_FFFF_FFFF_FF80);
        load_chk("lbu10", 2'd0, 1'b1, 64'h10, 64'h80);
        load_chk("lw14",  2'd2, 1'b0, 64'h14, 64'hFFFF_FFFF_FFFF_FFFF);
        load_chk("lwu14", 2'd2, 1'b1, 64'h14, 64'h0000_0000_FFFF_FFFF);
        load_chk("ldu10", 2'd3, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FF80);

        // SH merges into old word 3
        do_req(1'b1, 2'd1, 1'b0, 64'h1A, 64'h0000_0000_0000_BEEF);
        check_eq("sh_rd_cyc",   64'(rd_cyc),   64'd1);
        check_eq("sh_wr_cyc",   64'(wr_cyc),   64'd2);
        check_eq("sh_wr_cnt",   64'(wr_cnt),   64'd1);
        check_eq("sh_add",      wr_add,        64'd3);
        check_eq("sh_wdata",    wr_dat,        64'h0000_0000_BEEF_0003);
        check_eq("sh_resp_cyc", 64'(resp_cyc), 64'd3);
        check_eq("sh_overlap",  64'(overlap),  64'd0);
        check_eq("sh_stall",    64'(stall_lo), 64'd0);

        load_chk("lhu1a", 2'd1, 1'b1, 64'h1A, 64'h0000_0000_0000_BEEF);
        load_chk("lh1a",  2'd1, 1'b0, 64'h1A, 64'hFFFF_FFFF_FFFF_BEEF);
        load_chk("ld18",  2'd3, 1'b0, 64'h18, 64'h0000_0000_BEEF_0003);
        load_chk("ldwrap", 2'd3, 1'b0, 64'h2028, 64'd5);

        // LW at 0x06
        do_req(1'b0, 2'd2, 1'b0, 64'h06, 64'd0);
`ifdef LSU_ALIGN_CHECK_EN
        check_eq("mis_resp_cyc", 64'(resp_cyc), 64'd1);
        check_eq("mis_err",      {63'd0, r_err}, 64'd1);
        check_eq("mis_rd_cnt",   64'(rd_cnt),   64'd0);
        check_eq("mis_wr_cnt",   64'(wr_cnt),   64'd0);
`else
        check_eq("mis_resp_cyc", 64'(resp_cyc), 64'd2);
        check_eq("mis_err",      {63'd0, r_err}, 64'd0);
        check_eq("mis_rd_add",   rd_add,        64'd0);
        check_eq("mis_rd_cnt",   64'(rd_cnt),   64'd1);
`endif
        check_eq("mis_data", r_data, 64'd0);

        // Reset during WRITE of SB 0xAA at 0x08
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'h08; req_wdata = 64'hAA; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check_eq("sb_memrd", {63'd0, memread}, 64'd1);
        @(negedge clock);
        check_eq("sb_memwr",  {63'd0, memwrite}, 64'd1);
        check_eq("sb_add",    add,               64'd1);
        check_eq("sb_wdata",  write_data,        64'hAA);
        #1 reset = 1'b1;
        #1;
        check_eq("rstw_memwr", {63'd0, memwrite},   64'd0);
        check_eq("rstw_memrd", {63'd0, memread},    64'd0);
        check_eq("rstw_resp",  {63'd0, resp_valid}, 64'd0);
        check_eq("rstw_ready", {63'd0, req_ready},  64'd1);
        resp_in_rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (resp_valid || memwrite) resp_in_rst++;
        end
        reset = 1'b0;
        @(negedge clock);
        if (resp_valid) resp_in_rst++;
        check_eq("rstw_no_resp", 64'(resp_in_rst), 64'd0);
        check_eq("rstw_ready_after", {63'd0, req_ready}, 64'd1);
        @(posedge clock);
        #1;
        load_chk("ld08_old", 2'd3, 1'b0, 64'h08, 64'd1);

        // Back-to-back loads with req_valid held
        req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h28; req_valid = 1'b1;
        @(posedge clock);
        #1 req_addr = 64'h30;
        first_resp = 0; acc2 = 0; second_resp = 0; stall_bad = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (!req_ready && !stall) stall_bad++;
            if (resp_valid && first_resp == 0) begin
                first_resp = c;
                d1 = resp_rdata;
            end else if (resp_valid) begin
                second_resp = c;
                d2 = resp_rdata;
                break;
            end
            if (req_valid && req_ready && acc2 == 0) begin
                acc2 = c;
                @(posedge clock);
                #1 req_valid = 1'b0;
            end
        end
        check_eq("b2b_resp1_cyc", 64'(first_resp),  64'd2);
        check_eq("b2b_data1",     d1,               64'd5);
        check_eq("b2b_acc2_cyc",  64'(acc2),        64'd3);
        check_eq("b2b_resp2_cyc", 64'(second_resp), 64'd5);
        check_eq("b2b_data2",     d2,               64'd6);
        check_eq("b2b_stall",     64'(stall_bad),   64'd0);

        @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
